program_sequencer: RTL and testbench

- Run-control FSM sitting between the external req/ack handshake and the single-cycle core (program counter, register file, data memory).
- Selects one of several resident programs and holds the PC in start while loading that program's entry address.
- Enables architectural writes only while the program runs, detects the program's done address, and counts cycles.
- Aborts on a watchdog timeout or an illegal program select, and reports completion or fault on ack.

---
 rtl/program_sequencer_pkg.sv | 40 ++++
 rtl/program_sequencer_run_counter.sv | 43 ++++
 rtl/program_sequencer.sv | 129 ++++++++++++
 tb/tb_program_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared types and program tables for the run-control sequencer.
// No logic; the entry/done address lookups are pure combinational helpers.
// No flow control.
package program_sequencer_pkg;

  // Run-control states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    ACK   = 3'd3,
    FAULT = 3'd4
  } seq_state_t;

  // Number of entries held in the resident program tables.
  localparam int PROG_TABLE_LEN = 3;

  // Entry and final-instruction addresses of each resident program.
  localparam logic [31:0] START_ADDR [PROG_TABLE_LEN] = '{32'd0,   32'd150, 32'd300};
  localparam logic [31:0] DONE_ADDR  [PROG_TABLE_LEN] = '{32'd149, 32'd299, 32'd435};

  // Entry address of program sel; unknown indices fall back to program 0.
  function automatic logic [31:0] prog_start_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    return START_ADDR[1];
      2'd2:    return START_ADDR[2];
      default: return START_ADDR[0];
    endcase
  endfunction

  // Done address of program sel; unknown indices fall back to program 0.
  function automatic logic [31:0] prog_done_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    return DONE_ADDR[1];
      2'd2:    return DONE_ADDR[2];
      default: return DONE_ADDR[0];
    endcase
  endfunction

endpackage

// File: rtl/program_sequencer_run_counter.sv
// Cycle counter with synchronous clear, enable and a limit-reached flag.
// Count updates one cycle after en_i; limit_o is decoded from the register.
// No flow control; the count freezes once it equals LIMIT so it never wraps.
module run_counter #(
  parameter int          CNT_BITS = 16,
  parameter int unsigned LIMIT    = 32'hFFF0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [CNT_BITS-1:0] count_o,
  output logic                limit_o
);

  localparam logic [CNT_BITS-1:0] LIMIT_V = CNT_BITS'(LIMIT);

  logic [CNT_BITS-1:0] count_q;
  logic [CNT_BITS-1:0] count_d;

  assign limit_o = (count_q == LIMIT_V);
  assign count_o = count_q;

  // Next count: clear wins, otherwise count up while enabled and below the limit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !limit_o) begin
      count_d = count_q + CNT_BITS'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Run-control FSM between the req/ack handshake and the single-cycle core.
// req seen in IDLE -> LOAD next edge; LOAD lasts LOAD_CYCLES; ack one edge after done.
// req is a level: dropping it aborts LOAD/RUN or releases ack; outputs decode from state only.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int          PC_BITS        = 10,
  parameter int          NUM_PROGS      = 3,
  parameter int          LOAD_CYCLES    = 2,
  parameter int          CNT_BITS       = 16,
  parameter int unsigned WATCHDOG_LIMIT = 32'hFFF0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req,
  input  logic [1:0]          prog_sel,
  input  logic [PC_BITS-1:0]  pc,
  output logic                start,
  output logic [PC_BITS-1:0]  start_addr,
  output logic                run_en,
  output logic                ack,
  output logic                fault,
  output logic                busy,
  output logic [CNT_BITS-1:0] cycle_count
);

  localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

  seq_state_t   state_q, state_d;
  logic [1:0]   sel_q, sel_d;
  logic [3:0]   load_q, load_d;
  logic         cnt_clr;
  logic         cnt_en;
  logic         timeout;
  logic         done_hit;
  logic [PC_BITS-1:0] done_addr;

  // Cycle counter doubles as the watchdog: its limit flag is the timeout.
  run_counter #(
    .CNT_BITS (CNT_BITS),
    .LIMIT    (WATCHDOG_LIMIT)
  ) u_run_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cycle_count),
    .limit_o (timeout)
  );

  assign done_addr = PC_BITS'(prog_done_addr(sel_q));
  assign done_hit  = (pc == done_addr);

  // Outputs are pure decodes of the state and latched program select.
  assign start      = (state_q == LOAD);
  assign run_en     = (state_q == RUN);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign ack        = (state_q == ACK) || (state_q == FAULT);
  assign fault      = (state_q == FAULT);
  assign start_addr = PC_BITS'(prog_start_addr(sel_q));

  // Next-state logic; abort on req low has priority over done, done over timeout.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    load_d  = load_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        load_d = '0;
        if (req) begin
          // Every accepted request starts a fresh count, even an illegal one.
          cnt_clr = 1'b1;
          if (32'(prog_sel) < NUM_PROGS) begin
            sel_d   = prog_sel;
            state_d = LOAD;
          end else begin
            state_d = FAULT;
          end
        end
      end
      LOAD: begin
        if (!req) begin
          state_d = IDLE;
          load_d  = '0;
        end else if (load_q == LOAD_LAST) begin
          state_d = RUN;
          load_d  = '0;
        end else begin
          load_d = load_q + 4'd1;
        end
      end
      RUN: begin
        // Every RUN cycle is counted, including the done and abort cycles.
        cnt_en = 1'b1;
        if (!req) begin
          state_d = IDLE;
        end else if (done_hit) begin
          state_d = ACK;
        end else if (timeout) begin
          state_d = FAULT;
        end
      end
      ACK, FAULT: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, program select and load-phase counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req, req_w;
  logic [1:0]  prog_sel, prog_sel_w;
  logic [9:0]  pc, pc_w;

  logic        start, run_en, ack, fault, busy;
  logic [9:0]  start_addr;
  logic [15:0] cycle_count;

  logic        start_w, run_en_w, ack_w, fault_w, busy_w;
  logic [9:0]  start_addr_w;
  logic [15:0] cycle_count_w;

  always #5 clock = ~clock;

  program_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .prog_sel    (prog_sel),
    .pc          (pc),
    .start       (start),
    .start_addr  (start_addr),
    .run_en      (run_en),
    .ack         (ack),
    .fault       (fault),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  program_sequencer #(.WATCHDOG_LIMIT(20)) dut_wd (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req_w),
    .prog_sel    (prog_sel_w),
    .pc          (pc_w),
    .start       (start_w),
    .start_addr  (start_addr_w),
    .run_en      (run_en_w),
    .ack         (ack_w),
    .fault       (fault_w),
    .busy        (busy_w),
    .cycle_count (cycle_count_w)
  );

  localparam int S_START = 0, S_ADDR = 1, S_RUN = 2, S_ACK = 3, S_FAULT = 4, S_BUSY = 5, S_CNT = 6;
  localparam int W_START = 10, W_ADDR = 11, W_RUN = 12, W_ACK = 13, W_FAULT = 14, W_BUSY = 15, W_CNT = 16;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_START: return {31'b0, start};
      S_ADDR:  return {22'b0, start_addr};
      S_RUN:   return {31'b0, run_en};
      S_ACK:   return {31'b0, ack};
      S_FAULT: return {31'b0, fault};
      S_BUSY:  return {31'b0, busy};
      S_CNT:   return {16'b0, cycle_count};
      W_START: return {31'b0, start_w};
      W_ADDR:  return {22'b0, start_addr_w};
      W_RUN:   return {31'b0, run_en_w};
      W_ACK:   return {31'b0, ack_w};
      W_FAULT: return {31'b0, fault_w};
      W_BUSY:  return {31'b0, busy_w};
      W_CNT:   return {16'b0, cycle_count_w};
      default: return '1;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = observe(e.sig);
      checks++;
      assert (o === e.exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; prog_sel = 2'd0; pc = 10'd0;
    req_w = 1'b0; prog_sel_w = 2'd0; pc_w = 10'd5;
    repeat (2) @(posedge clock);
    #1;
    expect_val("rst_start", S_START, 0);
    expect_val("rst_busy", S_BUSY, 0);
    expect_val("rst_run_en", S_RUN, 0);
    expect_val("rst_ack", S_ACK, 0);
    expect_val("rst_fault", S_FAULT, 0);
    expect_val("rst_count", S_CNT, 0);
    expect_val("rst_addr", S_ADDR, 0);
    drain();
    reset_n = 1'b1;
    tick();

    // Normal run of program 2.
    prog_sel = 2'd2; req = 1'b1; pc = 10'd300;
    expect_val("load1_start", S_START, 1);
    expect_val("load1_addr", S_ADDR, 300);
    expect_val("load1_busy", S_BUSY, 1);
    expect_val("load1_run_en", S_RUN, 0);
    tick(); drain();
    prog_sel = 2'd1;
    expect_val("load2_start", S_START, 1);
    expect_val("load2_addr", S_ADDR, 300);
    tick(); drain();
    expect_val("run1_start", S_START, 0);
    expect_val("run1_run_en", S_RUN, 1);
    expect_val("run1_count", S_CNT, 0);
    tick(); drain();
    for (int k = 2; k <= 136; k++) begin
      tick();
      pc = 10'(300 + k - 1);
    end
    expect_val("run136_count", S_CNT, 135);
    expect_val("run136_run_en", S_RUN, 1);
    drain();
    expect_val("done_ack", S_ACK, 1);
    expect_val("done_fault", S_FAULT, 0);
    expect_val("done_run_en", S_RUN, 0);
    expect_val("done_busy", S_BUSY, 0);
    expect_val("done_count", S_CNT, 136);
    tick(); drain();

    // req held high after ack: no restart.
    expect_val("hold_ack", S_ACK, 1);
    expect_val("hold_start", S_START, 0);
    expect_val("hold_count", S_CNT, 136);
    repeat (3) tick();
    drain();
    req = 1'b0;
    expect_val("release_ack", S_ACK, 0);
    expect_val("release_busy", S_BUSY, 0);
    tick(); drain();

    // req low one cycle then high: new run, done address during LOAD ignored.
    req = 1'b1; prog_sel = 2'd0; pc = 10'd149;
    expect_val("rerun_start", S_START, 1);
    expect_val("rerun_addr", S_ADDR, 0);
    expect_val("rerun_count", S_CNT, 0);
    tick(); drain();
    expect_val("rerun_load2", S_START, 1);
    tick(); drain();
    expect_val("loaddone_run_en", S_RUN, 1);
    expect_val("loaddone_ack", S_ACK, 0);
    tick(); drain();
    pc = 10'd0;

    // Abort on RUN cycle 7.
    for (int k = 2; k <= 7; k++) begin
      tick();
      pc = 10'(k - 1);
    end
    req = 1'b0;
    expect_val("abort_busy", S_BUSY, 0);
    expect_val("abort_run_en", S_RUN, 0);
    expect_val("abort_ack", S_ACK, 0);
    expect_val("abort_count", S_CNT, 7);
    tick(); drain();
    expect_val("abort_hold_ack", S_ACK, 0);
    expect_val("abort_hold_count", S_CNT, 7);
    repeat (2) tick();
    drain();

    // Illegal program select.
    prog_sel = 2'd3; req = 1'b1;
    expect_val("illegal_ack", S_ACK, 1);
    expect_val("illegal_fault", S_FAULT, 1);
    expect_val("illegal_start", S_START, 0);
    expect_val("illegal_busy", S_BUSY, 0);
    expect_val("illegal_count", S_CNT, 0);
    tick(); drain();
    expect_val("illegal_start2", S_START, 0);
    expect_val("illegal_fault2", S_FAULT, 1);
    tick(); drain();
    req = 1'b0;
    expect_val("illegal_rel_ack", S_ACK, 0);
    expect_val("illegal_rel_fault", S_FAULT, 0);
    tick(); drain();

    // Reset mid-RUN.
    prog_sel = 2'd1; req = 1'b1; pc = 10'd150;
    repeat (4) tick();
    expect_val("midrun_busy", S_BUSY, 1);
    expect_val("midrun_run_en", S_RUN, 1);
    expect_val("midrun_addr", S_ADDR, 150);
    expect_val("midrun_count", S_CNT, 1);
    drain();
    reset_n = 1'b0;
    #2;
    expect_val("arst_busy", S_BUSY, 0);
    expect_val("arst_run_en", S_RUN, 0);
    expect_val("arst_start", S_START, 0);
    expect_val("arst_addr", S_ADDR, 0);
    expect_val("arst_count", S_CNT, 0);
    expect_val("arst_ack", S_ACK, 0);
    drain();
    tick();
    reset_n = 1'b1; req = 1'b0;
    expect_val("post_rst_busy", S_BUSY, 0);
    expect_val("post_rst_start", S_START, 0);
    tick(); drain();

    // Watchdog on the instance with a limit of 20.
    prog_sel_w = 2'd0; pc_w = 10'd5; req_w = 1'b1;
    expect_val("wd_load_start", W_START, 1);
    expect_val("wd_load_addr", W_ADDR, 0);
    tick(); drain();
    tick();
    expect_val("wd_run1_run_en", W_RUN, 1);
    expect_val("wd_run1_count", W_CNT, 0);
    tick(); drain();
    repeat (20) tick();
    expect_val("wd_limit_count", W_CNT, 20);
    expect_val("wd_limit_run_en", W_RUN, 1);
    expect_val("wd_limit_fault", W_FAULT, 0);
    drain();
    expect_val("wd_ack", W_ACK, 1);
    expect_val("wd_fault", W_FAULT, 1);
    expect_val("wd_run_en", W_RUN, 0);
    expect_val("wd_busy", W_BUSY, 0);
    expect_val("wd_count", W_CNT, 20);
    tick(); drain();
    expect_val("wd_hold_run_en", W_RUN, 0);
    tick(); drain();
    req_w = 1'b0;
    expect_val("wd_release_ack", W_ACK, 0);
    tick(); drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
